// File: rtl/pipe_skid_stage_pkg.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage_pkg
// Shared definitions for the elastic pipeline-stage register and the stage
// wrappers / hazard unit that pack and unpack its payload.
//   - default field widths (data word, rd index, control bits, counters)
//   - MEM/WB payload layout: {ctrl, rd, word[NWORDS-1] .. word[0]}
//   - occupancy state encoding shared with the stage FSM
// ---------------------------------------------------------------------------
package pipe_skid_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NWORDS_DEF = 3;
    localparam int CTRL_W_DEF = 4;
    localparam int RD_W_DEF   = 5;
    localparam int CNT_W_DEF  = 16;

    // Control bit positions inside the ctrl field.
    localparam int CTRL_REG_WRITE    = 0;
    localparam int CTRL_RESULT_SRC   = 1;
    localparam int CTRL_FP_REG_WRITE = 2;
    localparam int CTRL_FP_RESULT_SRC = 3;

    // Data word indices inside the words field.
    localparam int WORD_PC_PLUS4 = 0;
    localparam int WORD_ALU      = 1;
    localparam int WORD_RDATA    = 2;

    // Occupancy of the stage; the encoding equals the entry count so it can
    // be presented directly on the occupancy output.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    function automatic int pay_width(input int ctrl_w, input int rd_w,
                                     input int nwords, input int data_w);
        return ctrl_w + rd_w + nwords * data_w;
    endfunction

    // Bit offset of data word k within the payload.
    function automatic int word_lsb(input int k, input int data_w);
        return k * data_w;
    endfunction

    // Bit offset of the rd field within the payload.
    function automatic int rd_lsb(input int nwords, input int data_w);
        return nwords * data_w;
    endfunction

    // Bit offset of the ctrl field within the payload.
    function automatic int ctrl_lsb(input int rd_w, input int nwords,
                                    input int data_w);
        return rd_w + nwords * data_w;
    endfunction

endpackage

// File: rtl/pipe_skid_stage_if.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage_if
// One valid/ready channel carrying a PAY_W-bit payload.
//   valid   : producer has a payload this cycle
//   ready   : consumer accepts this cycle
//   payload : transported data
// Modports:
//   master : producer side (drives valid/payload, observes ready)
//   slave  : consumer side (observes valid/payload, drives ready)
// ---------------------------------------------------------------------------
interface pipe_skid_stage_if #(
    parameter int PAY_W = 105
);
    logic             valid;
    logic             ready;
    logic [PAY_W-1:0] payload;

    modport master (
        output valid,
        output payload,
        input  ready
    );

    modport slave (
        input  valid,
        input  payload,
        output ready
    );

endinterface

// File: rtl/pipe_skid_stage_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage_sat_counter
// Saturating statistics counter. Adds 0..2 per cycle and sticks at the
// all-ones value instead of wrapping. clr has priority over the increment.
//   clk  : clock
//   rst  : asynchronous active-low reset, clears the count
//   clr  : synchronous clear
//   inc  : increment amount (0, 1 or 2)
//   cnt  : current count
// ---------------------------------------------------------------------------
module pipe_skid_stage_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [1:0]       inc,
    output logic [CNT_W-1:0] cnt
);

    // One extra bit catches the carry-out so overflow clamps instead of wrapping.
    logic [CNT_W:0] sum;

    assign sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (sum[CNT_W]) begin
            cnt <= '1;
        end else begin
            cnt <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// pipe_skid_stage
// Elastic pipeline-stage register with a 2-entry skid buffer. in_ready is
// decoded from registered occupancy only, so there is no combinational path
// from downstream ready to upstream ready. Payloads are strictly FIFO.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   flush      : synchronous kill of all held entries (drops same-cycle input)
//   clr_stats  : synchronous clear of both statistics counters
//   up         : upstream channel  (in_valid / in_ready / in_payload)
//   dn         : downstream channel (out_valid / out_ready / out_payload);
//                payload is all-zero whenever valid is low
//   occupancy  : entries held (0..2)
//   stall_cnt  : saturating count of cycles with out_valid & !out_ready
//   kill_cnt   : saturating count of entries discarded by flush
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OCC_EMPTY | nothing held, M and S zero, accepting
// OCC_ONE   | head in M, S zero, accepting (refill M on same-cycle drain)
// OCC_TWO   | head in M, next in S, not accepting until M drains
// ---------------------------------------------------------------------------
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NWORDS = NWORDS_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    clr_stats,
    pipe_skid_stage_if.slave        up,
    pipe_skid_stage_if.master       dn,
    output logic [1:0]              occupancy,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        kill_cnt
);

    localparam int PAY_W = pay_width(CTRL_W, RD_W, NWORDS, DATA_W);

    occ_e             state;
    logic [PAY_W-1:0] main_q;
    logic [PAY_W-1:0] skid_q;

    logic             acc;
    logic             drn;
    logic             stall_hit;
    logic [1:0]       stall_inc;
    logic [1:0]       kill_inc;

    // Handshake outputs come straight from the registered state.
    assign up.ready   = (state != OCC_TWO);
    assign dn.valid   = (state != OCC_EMPTY);
    assign dn.payload = dn.valid ? main_q : '0;
    assign occupancy  = state;

    assign acc = up.valid & up.ready;
    assign drn = dn.valid & dn.ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state  <= OCC_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (acc) begin
                        main_q <= up.payload;
                        state  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    case ({acc, drn})
                        2'b11: main_q <= up.payload;
                        2'b01: begin
                            main_q <= '0;
                            state  <= OCC_EMPTY;
                        end
                        2'b10: begin
                            skid_q <= up.payload;
                            state  <= OCC_TWO;
                        end
                        default: ;
                    endcase
                end
                OCC_TWO: begin
                    if (drn) begin
                        main_q <= skid_q;
                        skid_q <= '0;
                        state  <= OCC_ONE;
                    end
                end
                default: begin
                    state  <= OCC_EMPTY;
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

    // A flushed cycle is not a stall: the head is being discarded, not held.
    assign stall_hit = dn.valid & ~dn.ready & ~flush;
    assign stall_inc = {1'b0, stall_hit};
    assign kill_inc  = flush ? occupancy : 2'd0;

    pipe_skid_stage_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    pipe_skid_stage_sat_counter #(
        .CNT_W (CNT_W)
    ) u_kill_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clr_stats),
        .inc (kill_inc),
        .cnt (kill_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// ---------------------------------------------------------------------------
// tb_pipe_skid_stage
// Self-checking bench: a queue-based model of the stage (at most two entries,
// FIFO order, saturating counters) is compared against the DUT on every
// falling edge, with directed sequences adding literal expectations.
// ---------------------------------------------------------------------------
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    localparam int DW  = 32;
    localparam int NW  = 3;
    localparam int CW  = 4;
    localparam int RW  = 5;
    localparam int CNW = 4;
    localparam int PW  = CW + RW + NW * DW;
    localparam int CMAX = (1 << CNW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic clr_stats = 1'b0;
    logic [1:0]     occupancy;
    logic [CNW-1:0] stall_cnt;
    logic [CNW-1:0] kill_cnt;

    pipe_skid_stage_if #(.PAY_W(PW)) up_if ();
    pipe_skid_stage_if #(.PAY_W(PW)) dn_if ();

    pipe_skid_stage #(
        .DATA_W (DW),
        .NWORDS (NW),
        .CTRL_W (CW),
        .RD_W   (RW),
        .CNT_W  (CNW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .clr_stats (clr_stats),
        .up        (up_if.slave),
        .dn        (dn_if.master),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .kill_cnt  (kill_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model
    logic [PW-1:0] mq[$];
    int            m_stall = 0;
    int            m_kill  = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_stall = 0;
            m_kill  = 0;
        end else begin
            int  n;
            bit  acc;
            bit  drn;
            n   = mq.size();
            acc = up_if.valid && (n < 2);
            drn = (n > 0) && dn_if.ready;
            if (clr_stats) begin
                m_stall = 0;
                m_kill  = 0;
            end else begin
                if ((n > 0) && !dn_if.ready && !flush) m_stall = sat(m_stall + 1);
                if (flush) m_kill = sat(m_kill + n);
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (drn) void'(mq.pop_front());
                if (acc) mq.push_back(up_if.payload);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst) begin
            logic [PW-1:0] exp_pay;
            exp_pay = (mq.size() > 0) ? mq[0] : '0;
            chk("in_ready",    128'(up_if.ready), 128'(mq.size() != 2));
            chk("out_valid",   128'(dn_if.valid), 128'(mq.size() != 0));
            chk("out_payload", 128'(dn_if.payload), 128'(exp_pay));
            chk("occupancy",   128'(occupancy), 128'(mq.size()));
            chk("stall_cnt",   128'(stall_cnt), 128'(m_stall));
            chk("kill_cnt",    128'(kill_cnt), 128'(m_kill));
        end
    end

    // Apply one cycle of inputs, then return just after the sampling edge.
    task automatic step(input bit iv, input logic [PW-1:0] p, input bit ordy,
                        input bit fl, input bit clr);
        @(negedge clk);
        #1;
        up_if.valid   = iv;
        up_if.payload = p;
        dn_if.ready   = ordy;
        flush         = fl;
        clr_stats     = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW-1:0] rnd_pay();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[PW-1:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        up_if.valid   = 1'b0;
        up_if.payload = '0;
        dn_if.ready   = 1'b0;

        // Reset state
        #12;
        chk("rst_occ",    128'(occupancy), 128'(0));
        chk("rst_ready",  128'(up_if.ready), 128'(1));
        chk("rst_valid",  128'(dn_if.valid), 128'(0));
        chk("rst_pay",    128'(dn_if.payload), 128'(0));
        @(negedge clk);
        #2;
        rst    = 1'b1;
        chk_en = 1'b1;

        // Streaming with out_ready high
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, PW'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_pay", 128'(dn_if.payload), 128'(i));
            chk("stream_occ", 128'(occupancy), 128'(1));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("stream_empty", 128'(occupancy), 128'(0));
        chk("stream_stall", 128'(stall_cnt), 128'(0));

        // Fill the skid buffer then release
        step(1'b1, PW'('hA), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'('hB), 1'b0, 1'b0, 1'b0);
        chk("fill_occ",   128'(occupancy), 128'(2));
        chk("fill_ready", 128'(up_if.ready), 128'(0));
        chk("fill_stall1", 128'(stall_cnt), 128'(1));
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("fill_stall2", 128'(stall_cnt), 128'(2));
        chk("fill_head",  128'(dn_if.payload), 128'('hA));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_head", 128'(dn_if.payload), 128'('hB));
        chk("drain_ready", 128'(up_if.ready), 128'(1));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", 128'(dn_if.valid), 128'(0));

        // Flush at occupancy 2 with a colliding input
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, PW'('h11), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'('h12), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'('hC), 1'b0, 1'b1, 1'b0);
        chk("flush_occ",   128'(occupancy), 128'(0));
        chk("flush_kill",  128'(kill_cnt), 128'(2));
        chk("flush_ready", 128'(up_if.ready), 128'(1));
        chk("flush_pay",   128'(dn_if.payload), 128'(0));
        step(1'b1, PW'('hD), 1'b1, 1'b0, 1'b0);
        chk("after_flush", 128'(dn_if.payload), 128'('hD));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stall counter saturation and clear-wins
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, PW'('h5), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("stall_sat", 128'(stall_cnt), 128'(15));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("stall_clr", 128'(stall_cnt), 128'(0));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Kill counter clamps on a two-entry kill near saturation
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, PW'(2 * k + 1), 1'b0, 1'b0, 1'b0);
            step(1'b1, PW'(2 * k + 2), 1'b0, 1'b0, 1'b0);
            step(1'b0, '0, 1'b0, 1'b1, 1'b0);
            if (k == 6) chk("kill_14", 128'(kill_cnt), 128'(14));
        end
        chk("kill_sat", 128'(kill_cnt), 128'(15));

        // Randomized traffic under several out_ready patterns
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 600; c++) begin
                bit ordy;
                case (ph)
                    0: ordy = $urandom_range(0, 1) == 1;
                    1: ordy = c[0];
                    2: ordy = $urandom_range(0, 7) != 0;
                    default: ordy = $urandom_range(0, 3) == 0;
                endcase
                step($urandom_range(0, 3) != 0, rnd_pay(), ordy,
                     $urandom_range(0, 39) == 0, $urandom_range(0, 63) == 0);
            end
        end

        // Asynchronous reset while full
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, PW'('h21), 1'b0, 1'b0, 1'b0);
        step(1'b1, PW'('h22), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_occ", 128'(occupancy), 128'(2));
        #2;
        rst = 1'b0;
        #1;
        chk("arst_occ",   128'(occupancy), 128'(0));
        chk("arst_pay",   128'(dn_if.payload), 128'(0));
        chk("arst_ready", 128'(up_if.ready), 128'(1));
        chk("arst_stall", 128'(stall_cnt), 128'(0));
        chk("arst_kill",  128'(kill_cnt), 128'(0));
        @(negedge clk);
        #2;
        rst = 1'b1;
        step(1'b1, PW'('h33), 1'b1, 1'b0, 1'b0);
        chk("post_rst", 128'(dn_if.payload), 128'('h33));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
